kb_matrix_scanner: RTL and testbench
====================================

// Module: kb_matrix_scanner
// PURPOSE
// - Parametrised ROWSxCOLS keypad matrix scanner. Drives one active-low column at a time and samples active-low rows.
// - Debounces every key on a per-scan basis and keeps independent per-key toggle bits, or level state in level mode.
// - Emits press/release events through a valid/ready event queue. Sits between the keypad pins and the display/decoder logic.
// PARAMETERS
// - ROWS       4    number of row inputs (>=1)
// - COLS       4    number of column outputs (>=2)
// - SCAN_DIV   1000 clk cycles each column is driven; must be >= ROWS+2
// - DEB_CNT    4    consecutive disagreeing samples needed to flip a key's stable state (>=1)
// - EVQ_DEPTH  4    event queue depth, power of two, >=2
// PORTS
// - clk          in   1               system clock
// - rst          in   1               synchronous, active-high reset
// - kb_row       in   ROWS            row sense, active-low (0 = key closed on driven column)
// - kb_col       out  COLS            column drive, one-cold, registered
// - mode_toggle  in   1               1 = mem_val toggles per press; 0 = mem_val follows key_state
// - clr          in   1               sync clear of mem_val and ev_overflow
// - key_state    out  ROWS*COLS       debounced level per key, bit r*COLS+c
// - mem_val      out  ROWS*COLS       toggle/level memory, same bit mapping
// - ev_valid     out  1               queue head valid
// - ev_ready     in   1               consumer accepts head when ev_valid&ev_ready
// - ev_code      out  $clog2(ROWS*COLS) key index r*COLS+c of head event
// - ev_press     out  1               1 = press, 0 = release
// - ev_overflow  out  1               sticky: an event was dropped on a full queue
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge): col_idx=0, dwell=0, kb_col={1..1,0} (col0 low), key_state=0, mem_val=0, all debounce counters=0, pending=0, queue empty, ev_valid=0, ev_overflow=0. Reset mid-dwell or mid-drain discards pending/queued events.
// - Scan: dwell counts 0..SCAN_DIV-1. At dwell==SCAN_DIV-1 the rows are sampled for col_idx and col_idx advances (COLS-1 wraps to 0). kb_col updates on the same edge.
// - Debounce, per key of the sampled column: sample==stable -> cnt=0; else cnt+1. On reaching DEB_CNT: stable flips, cnt=0, pending[row]=1. key_state is updated on that edge.
// - Drain: from the cycle after sampling, one pending row per cycle, lowest row first, is pushed as {press=new stable, code}. All pending rows drain before the next sample (guaranteed by the SCAN_DIV constraint).
// - Toggle mode: mem_val bit inverts on each press push, not on release. Keys are fully independent; multiple presses in one column all take effect.
// - Level mode: mem_val<=key_state every cycle. Switching to toggle mode keeps the current mem_val value as the starting point.
// - clr: mem_val<=0 and ev_overflow<=0. clr has priority over a same-cycle toggle. The queue is untouched.
// - Queue: FIFO, registered outputs; ev_valid rises the cycle after a push into an empty queue. Pop when ev_valid&ev_ready.
// - Push when full: event dropped and ev_overflow<=1. key_state and mem_val still update.
// - Push and pop in the same cycle while full: push accepted, no overflow.
// - ev_code/ev_press are don't-care while ev_valid=0. Head is stable while ev_valid&!ev_ready.
// STRUCTURE
// - kb_pkg: KEY_N=ROWS*COLS, KEY_W=$clog2(KEY_N), kb_ev_t {logic press; logic [KEY_W-1:0] code}, key_idx(r,c) function.
// - Sub-module kb_evq: sync FIFO of kb_ev_t (depth EVQ_DEPTH, full/empty, overflow flag), sync active-high rst.
// - Top holds the scan counter, per-key debounce counters/stable bits, the pending arbiter and the mem_val logic.
// TESTING (ROWS=COLS=4, SCAN_DIV=8, DEB_CNT=3, EVQ_DEPTH=4)
// - Reset -> kb_col=4'b1110, key_state=0, mem_val=0, ev_valid=0, ev_overflow=0; kb_col sequence 1110,1101,1011,0111 every 8 clks.
// - Hold r1c2 for 3 scans (toggle mode) -> event {press=1, code=6}, key_state[6]=1, mem_val[6]=1.
// - Continue r1c2 case: release for 3 scans -> {0,6}, mem_val[6] stays 1; second press -> mem_val[6]=0.
// - r2c0 closed for 2 scans then open -> no event, counter back to 0, key_state unchanged.
// - r0c1 and r3c1 closed together -> events {1,1} then {1,13} on consecutive pushes, mem_val=16'h2002.
// - ev_ready=0, 5 events generated -> 4 queued in order, ev_overflow=1; clr -> ev_overflow=0, mem_val=0, queue still holds 4.
// - Full queue with simultaneous pop and push -> no overflow.
// - mode_toggle=0 -> mem_val==key_state each cycle.
// - rst asserted mid-drain -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/kb_pkg.sv
// kb_pkg: shared definitions for the keypad matrix scanner.
//   KB_ROWS/KB_COLS : default matrix geometry; the scanner's ROWS/COLS
//                     parameters default to these and must stay equal to
//                     them, because the event type is sized from KEY_W.
//   KEY_N/KEY_W     : number of keys and width of a key index.
//   kb_ev_t         : one press/release event {press, code}.
//   key_idx(r, c)   : flat key index r*COLS+c.
package kb_pkg;

    localparam int KB_ROWS = 4;
    localparam int KB_COLS = 4;
    localparam int KEY_N   = KB_ROWS * KB_COLS;
    localparam int KEY_W   = (KEY_N > 1) ? $clog2(KEY_N) : 1;

    typedef struct packed {
        logic             press;
        logic [KEY_W-1:0] code;
    } kb_ev_t;

    function automatic logic [KEY_W-1:0] key_idx(input int r, input int c);
        int k;
        k = r * KB_COLS + c;
        return k[KEY_W-1:0];
    endfunction

endpackage

// File: rtl/kb_evq.sv
// kb_evq: synchronous FIFO of kb_ev_t events with a sticky overflow flag.
//   clk, rst       : clock, synchronous active-high reset (empties queue)
//   push, push_ev  : write request and event
//   pop_ready      : consumer ready; head is popped when valid & pop_ready
//   clr            : clears the overflow flag
//   valid, head    : queue head (head is don't-care while valid=0)
//   overflow       : sticky, set when a push is dropped on a full queue
module kb_evq
    import kb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  kb_ev_t push_ev,
    input  logic   pop_ready,
    input  logic   clr,
    output logic   valid,
    output kb_ev_t head,
    output logic   overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    kb_ev_t        mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          full, pop, wr_en;

    always_comb begin
        full  = (cnt_q == NW'(DEPTH));
        pop   = valid_q & pop_ready;
        // A pop on the same edge frees the slot the push needs.
        wr_en = push & (~full | pop);
        rd_d  = pop   ? rd_q + 1'b1 : rd_q;
        wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
        cnt_d = cnt_q + NW'(wr_en) - NW'(pop);
        valid_d = (cnt_d != '0);
        ovf_d = ovf_q;
        if (clr)
            ovf_d = 1'b0;
        else if (push && !wr_en)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is data only; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_q] <= push_ev;
    end

    assign valid    = valid_q;
    assign head     = mem_q[rd_q];
    assign overflow = ovf_q;

endmodule

// File: rtl/kb_matrix_scanner.sv
// kb_matrix_scanner: ROWSxCOLS keypad scanner with per-key debounce,
// toggle/level key memory and a press/release event queue.
//   clk, rst     : clock, synchronous active-high reset
//   kb_row       : active-low row sense for the currently driven column
//   kb_col       : one-cold registered column drive
//   mode_toggle  : 1 = mem_val toggles per press, 0 = mem_val tracks key_state
//   clr          : clears mem_val and ev_overflow
//   key_state    : debounced level per key (bit r*COLS+c)
//   mem_val      : toggle/level memory, same mapping
//   ev_valid/ev_ready/ev_code/ev_press : event queue head handshake
//   ev_overflow  : sticky, an event was dropped on a full queue
module kb_matrix_scanner
    import kb_pkg::*;
#(
    parameter int ROWS      = KB_ROWS,
    parameter int COLS      = KB_COLS,
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_CNT   = 4,
    parameter int EVQ_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROWS-1:0]  kb_row,
    output logic [COLS-1:0]  kb_col,
    input  logic             mode_toggle,
    input  logic             clr,
    output logic [KEY_N-1:0] key_state,
    output logic [KEY_N-1:0] mem_val,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [KEY_W-1:0] ev_code,
    output logic             ev_press,
    output logic             ev_overflow
);

    localparam int DW    = $clog2(SCAN_DIV);
    localparam int CW    = $clog2(COLS);
    localparam int CNT_W = $clog2(DEB_CNT + 1);

    logic [DW-1:0]                dwell_q, dwell_d;
    logic [CW-1:0]                col_idx_q, col_idx_d;
    logic [CW-1:0]                drain_col_q, drain_col_d;
    logic [COLS-1:0]              kb_col_q, kb_col_d;
    logic [KEY_N-1:0]             stable_q, stable_d;
    logic [KEY_N-1:0]             mem_val_q, mem_val_d;
    logic [KEY_N-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROWS-1:0]              pending_q, pending_d;
    logic                         sample, push;
    kb_ev_t                       push_ev, head_ev;

    always_comb begin
        sample      = (dwell_q == DW'(SCAN_DIV - 1));
        dwell_d     = sample ? '0 : dwell_q + 1'b1;
        col_idx_d   = col_idx_q;
        kb_col_d    = kb_col_q;
        drain_col_d = drain_col_q;
        stable_d    = stable_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        push        = 1'b0;
        push_ev     = '0;

        // Drain: lowest pending row of the last sampled column, one per cycle.
        // The stable bit already holds the new level, so it is the press flag.
        for (int r = 0; r < ROWS; r++) begin
            if (!push && pending_q[r]) begin
                push         = 1'b1;
                pending_d[r] = 1'b0;
                push_ev.code  = key_idx(r, int'(drain_col_q));
                push_ev.press = stable_q[key_idx(r, int'(drain_col_q))];
            end
        end

        if (sample) begin
            col_idx_d   = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
            kb_col_d    = ~(COLS'(1) << col_idx_d);
            drain_col_d = col_idx_q;
            for (int r = 0; r < ROWS; r++) begin
                // Rows are active-low: 0 means the key is closed.
                if (!kb_row[r] == stable_q[key_idx(r, int'(col_idx_q))]) begin
                    cnt_d[key_idx(r, int'(col_idx_q))] = '0;
                end else if (cnt_q[key_idx(r, int'(col_idx_q))] == CNT_W'(DEB_CNT - 1)) begin
                    stable_d[key_idx(r, int'(col_idx_q))] = !kb_row[r];
                    cnt_d[key_idx(r, int'(col_idx_q))]    = '0;
                    pending_d[r]                          = 1'b1;
                end else begin
                    cnt_d[key_idx(r, int'(col_idx_q))] =
                        cnt_q[key_idx(r, int'(col_idx_q))] + 1'b1;
                end
            end
        end

        // Level mode follows the next key_state so both change on the same
        // edge. Presses toggle even when the queue drops the event.
        mem_val_d = mem_val_q;
        if (clr)
            mem_val_d = '0;
        else if (!mode_toggle)
            mem_val_d = stable_d;
        else if (push && push_ev.press)
            mem_val_d[push_ev.code] = ~mem_val_q[push_ev.code];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q   <= '0;
            col_idx_q <= '0;
            kb_col_q  <= {{(COLS-1){1'b1}}, 1'b0};
            stable_q  <= '0;
            mem_val_q <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            dwell_q   <= dwell_d;
            col_idx_q <= col_idx_d;
            kb_col_q  <= kb_col_d;
            stable_q  <= stable_d;
            mem_val_q <= mem_val_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // Only meaningful while pending rows exist, which reset clears.
    always_ff @(posedge clk) begin
        drain_col_q <= drain_col_d;
    end

    kb_evq #(
        .DEPTH(EVQ_DEPTH)
    ) u_evq (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_ev  (push_ev),
        .pop_ready(ev_ready),
        .clr      (clr),
        .valid    (ev_valid),
        .head     (head_ev),
        .overflow (ev_overflow)
    );

    assign kb_col    = kb_col_q;
    assign key_state = stable_q;
    assign mem_val   = mem_val_q;
    assign ev_code   = head_ev.code;
    assign ev_press  = head_ev.press;

endmodule

// File: tb/tb_kb_matrix_scanner.sv
module tb_kb_matrix_scanner;
    import kb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  kb_row;
    logic [3:0]  kb_col;
    logic        mode_toggle;
    logic        clr;
    logic [15:0] key_state;
    logic [15:0] mem_val;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_code;
    logic        ev_press;
    logic        ev_overflow;

    logic [15:0] closed = '0;
    logic        lvl_chk = 1'b0;
    int          checks = 0;
    int          failures = 0;
    kb_ev_t      sb[$];

    kb_matrix_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEB_CNT(3), .EVQ_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .kb_row(kb_row), .kb_col(kb_col),
        .mode_toggle(mode_toggle), .clr(clr), .key_state(key_state),
        .mem_val(mem_val), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_press(ev_press), .ev_overflow(ev_overflow)
    );

    always #5 clk = ~clk;

    // Keypad model: a closed key pulls its row low while its column is driven.
    always_comb begin
        kb_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (kb_col[c] == 1'b0 && closed[r*4+c]) kb_row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input bit p, input int code);
        kb_ev_t e;
        e.press = p;
        e.code  = code[KEY_W-1:0];
        sb.push_back(e);
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((sb.size() != 0 || ev_valid !== 1'b0) && n < 400) begin
            clks(1);
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic settle();
        clks(4 * 32);
        wait_empty();
    endtask

    // Returns just after the edge on which column col was sampled n times.
    task automatic wait_col_sample(input int col, input int n);
        int seen = 0;
        int cyc = 0;
        logic [3:0] prev;
        while (seen < n && cyc < 300) begin
            prev = kb_col;
            clks(1);
            cyc++;
            if (prev[col] == 1'b0 && kb_col[col] == 1'b1) seen++;
        end
        check("col_sample_seen", 32'(seen), 32'(n));
    endtask

    // Scoreboard consumer plus the per-cycle level-mode comparison.
    always @(negedge clk) begin : mon
        kb_ev_t e;
        if (rst === 1'b0 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL ev_unexpected observed=%0d/%0h expected=none", ev_press, ev_code);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ev_code", 32'(ev_code), 32'(e.code));
                check("ev_press", 32'(ev_press), 32'(e.press));
            end
        end
        if (lvl_chk) check("level_mem", 32'(mem_val), 32'(key_state));
    end

    initial begin
        rst = 1'b1; mode_toggle = 1'b1; clr = 1'b0; ev_ready = 1'b1;
        clks(3);
        rst = 1'b0;
        check("rst_kb_col", 32'(kb_col), 32'hE);
        check("rst_key_state", 32'(key_state), 32'h0);
        check("rst_mem_val", 32'(mem_val), 32'h0);
        check("rst_ev_valid", 32'(ev_valid), 32'h0);
        check("rst_ev_overflow", 32'(ev_overflow), 32'h0);
        clks(8);  check("col_seq1", 32'(kb_col), 32'hD);
        clks(8);  check("col_seq2", 32'(kb_col), 32'hB);
        clks(8);  check("col_seq3", 32'(kb_col), 32'h7);
        clks(8);  check("col_seq0", 32'(kb_col), 32'hE);

        // r1c2 press / release / press / release in toggle mode
        closed[6] = 1'b1; expect_ev(1, 6); settle();
        check("r1c2_key", 32'(key_state), 32'h0040);
        check("r1c2_mem1", 32'(mem_val), 32'h0040);
        closed[6] = 1'b0; expect_ev(0, 6); settle();
        check("r1c2_rel_key", 32'(key_state), 32'h0);
        check("r1c2_rel_mem", 32'(mem_val), 32'h0040);
        closed[6] = 1'b1; expect_ev(1, 6); settle();
        check("r1c2_mem2", 32'(mem_val), 32'h0);
        closed[6] = 1'b0; expect_ev(0, 6); settle();

        // r2c0 bounces: two closed scans never reach the threshold, twice
        closed[8] = 1'b1; clks(64); closed[8] = 1'b0; clks(64);
        closed[8] = 1'b1; clks(64); closed[8] = 1'b0; clks(64);
        check("bounce_key", 32'(key_state), 32'h0);
        check("bounce_sb", 32'(sb.size()), 32'd0);

        // r0c1 and r3c1 together
        closed[1] = 1'b1; closed[13] = 1'b1;
        expect_ev(1, 1); expect_ev(1, 13); settle();
        check("two_mem", 32'(mem_val), 32'h2002);
        closed[1] = 1'b0; closed[13] = 1'b0;
        expect_ev(0, 1); expect_ev(0, 13); settle();
        check("two_rel_mem", 32'(mem_val), 32'h2002);

        // Overflow: four presses fill the queue, the fifth is dropped
        ev_ready = 1'b0;
        closed[0] = 1'b1; closed[4] = 1'b1; closed[8] = 1'b1; closed[12] = 1'b1;
        expect_ev(1, 0); expect_ev(1, 4); expect_ev(1, 8); expect_ev(1, 12);
        clks(128);
        check("full_no_ovf", 32'(ev_overflow), 32'h0);
        closed[2] = 1'b1; clks(128);
        check("ovf_flag", 32'(ev_overflow), 32'h1);
        check("ovf_key", 32'(key_state), 32'h1115);
        check("ovf_mem", 32'(mem_val), 32'h3117);
        clr = 1'b1; clks(1); clr = 1'b0;
        check("clr_mem", 32'(mem_val), 32'h0);
        check("clr_ovf", 32'(ev_overflow), 32'h0);
        check("clr_valid", 32'(ev_valid), 32'h1);

        // Pop and push on the same edge while full
        closed[2] = 1'b0; expect_ev(0, 2);
        wait_col_sample(2, 3);
        ev_ready = 1'b1; clks(1); ev_ready = 1'b0;
        check("popush_ovf", 32'(ev_overflow), 32'h0);
        check("popush_valid", 32'(ev_valid), 32'h1);
        ev_ready = 1'b1; wait_empty();
        check("popush_ovf2", 32'(ev_overflow), 32'h0);
        closed[0] = 1'b0; closed[4] = 1'b0; closed[8] = 1'b0; closed[12] = 1'b0;
        expect_ev(0, 0); expect_ev(0, 4); expect_ev(0, 8); expect_ev(0, 12);
        settle();

        // Level mode: mem_val tracks key_state every cycle
        mode_toggle = 1'b0; clks(1); lvl_chk = 1'b1;
        closed[15] = 1'b1; expect_ev(1, 15); settle();
        check("lvl_key", 32'(key_state), 32'h8000);
        closed[15] = 1'b0; expect_ev(0, 15); settle();
        lvl_chk = 1'b0; mode_toggle = 1'b1; clks(1);

        // Reset while column 0 is draining
        ev_ready = 1'b0;
        closed[0] = 1'b1; closed[4] = 1'b1; closed[8] = 1'b1; closed[12] = 1'b1;
        wait_col_sample(0, 3);
        clks(1);
        rst = 1'b1; closed = '0; clks(1); rst = 1'b0;
        check("mid_kb_col", 32'(kb_col), 32'hE);
        check("mid_key", 32'(key_state), 32'h0);
        check("mid_mem", 32'(mem_val), 32'h0);
        check("mid_valid", 32'(ev_valid), 32'h0);
        check("mid_ovf", 32'(ev_overflow), 32'h0);
        ev_ready = 1'b1; clks(160);
        check("mid_no_events", 32'(sb.size()), 32'd0);
        check("mid_valid2", 32'(ev_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
